// File: rtl/sr_latch_arbiter_if.sv
// Request/grant and SR latch drive bundle for sr_latch_arbiter.
// Master drives requests; slave (the arbiter) drives the latch side.
interface sr_latch_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] op;
  logic [NREQ-1:0] gnt;
  logic            s_out;
  logic            r_out;
  logic            busy;
  logic            done;
  logic            q_shadow;

  modport master (
    output req, op,
    input  gnt, s_out, r_out,
    input  busy, done, q_shadow
  );

  modport slave (
    input  req, op,
    output gnt, s_out, r_out,
    output busy, done, q_shadow
  );
endinterface

// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter that serialises set/reset pulses onto one SR latch.
// Each operation: PULSE_W cycles of S or R drive, then GUARD_W idle cycles.
module sr_latch_arbiter #(
  parameter int NREQ    = 4,
  parameter int PULSE_W = 2,
  parameter int GUARD_W = 1
) (
  input logic               clk,
  input logic               rst_n,
  sr_latch_arbiter_if.slave bus
);
  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (PULSE_W > GUARD_W) ? PULSE_W : GUARD_W;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GUARD
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic            op_q;
  logic            ready;
  logic [NREQ-1:0] gnt_q;
  logic            s_q;
  logic            r_q;
  logic            busy_q;
  logic            done_q;
  logic            q_q;

  logic [PW-1:0]   win;
  logic            hit;
  logic [PW:0]     sum;
  logic [PW-1:0]   idx;

  // First requester at or after ptr, wrapping around
  always_comb begin
    win = '0;
    hit = 1'b0;
    sum = '0;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ))
        sum = sum - (PW+1)'(NREQ);
      idx = sum[PW-1:0];
      if (!hit && bus.req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      op_q   <= 1'b0;
      ready  <= 1'b0;
      gnt_q  <= '0;
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      q_q    <= 1'b0;
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      // Holds off grants for one edge after reset release
      ready  <= 1'b1;
      unique case (state)
        IDLE: begin
          if (ready && hit) begin
            state  <= PULSE;
            gnt_q  <= NREQ'(1) << win;
            op_q   <= bus.op[win];
            s_q    <= bus.op[win];
            r_q    <= ~bus.op[win];
            busy_q <= 1'b1;
            cnt    <= CW'(PULSE_W - 1);
            ptr    <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state <= GUARD;
            cnt   <= CW'(GUARD_W - 1);
            s_q   <= 1'b0;
            r_q   <= 1'b0;
            if (GUARD_W == 1) begin
              done_q <= 1'b1;
              q_q    <= op_q;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GUARD: begin
          if (cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              done_q <= 1'b1;
              q_q    <= op_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.s_out    = s_q;
  assign bus.r_out    = r_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.q_shadow = q_q;
endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Bench for sr_latch_arbiter: directed scenarios plus random traffic,
// all outputs compared every cycle against an operation-timeline model.
module tb_sr_latch_arbiter;
  localparam int N = 4;
  localparam int P = 2;
  localparam int G = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sr_latch_arbiter_if #(.NREQ(N)) bus ();

  sr_latch_arbiter #(
    .NREQ   (N),
    .PULSE_W(P),
    .GUARD_W(G)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Model: an operation is described by its grant cycle, winner and op
  int   cyc = 0;
  int   m_gcyc;
  int   m_win;
  int   m_ptr;
  logic m_op;
  logic m_q;
  logic m_ready;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_gcyc  = -1000;
    m_win   = 0;
    m_ptr   = 0;
    m_op    = 1'b0;
    m_q     = 1'b0;
    m_ready = 1'b0;
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++)
      if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  task automatic compare();
    int   ph;
    logic act;
    ph  = cyc - m_gcyc;
    act = (ph < P + G);
    chk("gnt", 32'(bus.gnt),
        (act && ph == 0) ? (32'd1 << m_win) : 32'd0);
    chk("s_out", 32'(bus.s_out), 32'(act && ph < P && m_op));
    chk("r_out", 32'(bus.r_out), 32'(act && ph < P && !m_op));
    chk("busy", 32'(bus.busy), 32'(act));
    chk("done", 32'(bus.done), 32'(act && ph == P + G - 1));
    chk("q_shadow", 32'(bus.q_shadow), 32'(m_q));
    chk("sr_excl", 32'(bus.s_out && bus.r_out), 32'd0);
    chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
  endtask

  task automatic step();
    logic [N-1:0] r;
    logic [N-1:0] o;
    int           pb;
    int           w;
    r = bus.req;
    o = bus.op;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      pb = cyc - 1 - m_gcyc;
      if (!m_ready) begin
        m_ready = 1'b1;
      end else if (pb >= P + G && r != '0) begin
        w      = pick(r);
        m_win  = w;
        m_op   = o[w];
        m_gcyc = cyc;
        m_ptr  = (w + 1) % N;
      end
      if (cyc - m_gcyc == P + G - 1) m_q = m_op;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    step();
    rst_n = 1'b1;
  endtask

  logic [N-1:0] gq[$];
  logic         sq[$];
  int           didx;
  int           gidx;

  initial begin
    bus.req = '0;
    bus.op  = '0;
    model_reset();
    @(negedge clk);
    compare();
    rst_n = 1'b1;

    // Single set; first edge after release must not grant
    bus.req = 4'b0001;
    bus.op  = 4'b0001;
    step();
    chk("no_early_gnt", 32'(bus.gnt), 32'd0);
    step();
    chk("s1_gnt", 32'(bus.gnt), 32'd1);
    chk("s1_s", 32'(bus.s_out), 32'd1);
    bus.req = '0;
    step();
    chk("s1_s2", 32'(bus.s_out), 32'd1);
    step();
    chk("s1_done", 32'(bus.done), 32'd1);
    chk("s1_q", 32'(bus.q_shadow), 32'd1);
    step();
    chk("s1_idle", 32'(bus.busy), 32'd0);

    // All four held, alternating ops
    do_reset();
    bus.req = 4'b1111;
    bus.op  = 4'b0101;
    for (int i = 0; i < 18; i++) begin
      step();
      if (bus.gnt != '0) begin
        gq.push_back(bus.gnt);
        sq.push_back(bus.s_out);
      end
    end
    bus.req = '0;
    for (int i = 0; i < 4; i++) step();
    chk("rr_count", 32'(gq.size()), 32'd5);
    if (gq.size() == 5) begin
      chk("rr_g0", 32'(gq[0]), 32'h1);
      chk("rr_g1", 32'(gq[1]), 32'h2);
      chk("rr_g2", 32'(gq[2]), 32'h4);
      chk("rr_g3", 32'(gq[3]), 32'h8);
      chk("rr_g4", 32'(gq[4]), 32'h1);
      chk("rr_s", 32'({sq[0], sq[1], sq[2], sq[3], sq[4]}), 32'b10101);
    end
    chk("rr_q", 32'(bus.q_shadow), 32'd1);

    // Move ptr to 2, then wrap-around grant order
    bus.req = 4'b0010;
    bus.op  = 4'b0000;
    step();
    bus.req = '0;
    for (int i = 0; i < 4; i++) step();
    gq.delete();
    bus.req = 4'b0011;
    bus.op  = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.gnt != '0) begin
        gq.push_back(bus.gnt);
        bus.req = bus.req & ~bus.gnt;
      end
    end
    chk("wrap_count", 32'(gq.size()), 32'd2);
    if (gq.size() == 2) begin
      chk("wrap_g0", 32'(gq[0]), 32'h1);
      chk("wrap_g1", 32'(gq[1]), 32'h2);
    end

    // Request arriving mid-pulse waits until done+2
    bus.req = 4'b0001;
    bus.op  = 4'b0010;
    step();
    bus.req = 4'b0010;
    didx = -1;
    gidx = -1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.done && didx < 0) didx = i;
      if (bus.gnt != '0 && gidx < 0) begin
        gidx = i;
        bus.req = '0;
      end
    end
    chk("late_done", 32'(didx >= 0), 32'd1);
    chk("late_gnt", 32'(gidx), 32'(didx + 2));
    for (int i = 0; i < 4; i++) step();

    // Reset in the second pulse cycle of a set
    bus.req = 4'b0100;
    bus.op  = 4'b0100;
    step();
    bus.req = '0;
    step();
    chk("abort_pre_s", 32'(bus.s_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_s", 32'(bus.s_out), 32'd0);
    chk("abort_q", 32'(bus.q_shadow), 32'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    didx = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.done) didx++;
    end
    chk("abort_nodone", 32'(didx), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      bus.req = N'($urandom);
      bus.op  = N'($urandom);
      if ($urandom_range(63) == 0) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sr_latch_arbiter.md
SR_LATCH_ARBITER -- requirements
Module: sr_latch_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one SR latch (2..8).
REQ-002 Parameter PULSE_W, default 2, clock cycles of active S or R drive per operation (>=1).
REQ-003 Parameter GUARD_W, default 1, idle cycles with S=R=0 after each pulse (>=1).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req  input  NREQ  per-requester operation request, level, held until granted.
REQ-007 op  input  NREQ  per-requester operation: 1=set, 0=reset; sampled with req at grant.
REQ-008 gnt  output  NREQ  one-hot grant, one-cycle pulse.
REQ-009 s_out  output  1  S drive to latch.
REQ-010 r_out  output  1  R drive to latch.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse marking operation completion.
REQ-013 q_shadow  output  1  last value written to latch (1 after set, 0 after reset).

Function
REQ-014 All outputs SHALL be registered; s_out and r_out SHALL never be 1 in the same cycle.
REQ-015 FSM states: IDLE, PULSE, GUARD; encoding free.
REQ-016 IDLE: if any req bit set at edge k, winner = first set bit scanning from ptr upward with wrap; cycle k+1: state PULSE, gnt[winner]=1, op[winner] latched, counter = PULSE_W-1.
REQ-017 IDLE with req=0: stay IDLE, gnt=0, s_out=r_out=0.
REQ-018 PULSE: s_out=latched op, r_out=~latched op; counter decrements each cycle; leave to GUARD after exactly PULSE_W cycles in PULSE.
REQ-019 GUARD: s_out=r_out=0 for exactly GUARD_W cycles; done=1 and q_shadow=latched op in last GUARD cycle; next state IDLE.
REQ-020 Latency: req at edge k -> gnt and first S/R cycle at k+1 -> done at k+PULSE_W+GUARD_W -> next grant no earlier than k+PULSE_W+GUARD_W+2.
REQ-021 ptr SHALL update to (winner+1) mod NREQ at grant; round-robin fairness: a held request is granted within NREQ operations.
REQ-022 Requests arriving while busy are ignored until IDLE; a req dropped before grant produces no operation.
REQ-023 Operation requested equals q_shadow: pulse still issued (no skip).
REQ-024 Simultaneous requests with conflicting op: only winner's op executed; others wait.
REQ-025 gnt SHALL be 0 in every cycle except the first PULSE cycle.

Reset
REQ-026 rst_n low: immediately state=IDLE, gnt=0, s_out=0, r_out=0, busy=0, done=0, q_shadow=0, ptr=0, counter=0.
REQ-027 Reset mid-PULSE or mid-GUARD aborts operation with no done pulse and no q_shadow update.
REQ-028 First grant after rst_n release occurs no earlier than the second rising edge with rst_n high.

Verification (NREQ=4, PULSE_W=2, GUARD_W=1)
REQ-029 req=0001, op=0001 at edge k -> gnt=0001 at k+1, s_out=1 at k+1..k+2, r_out=0, done=1 and q_shadow=1 at k+3, busy low k+4.
REQ-030 req=1111 held, op=0101 -> grants 0001,0010,0100,1000,0001 in order; s/r pattern S,R,S,R,S; q_shadow ends 1.
REQ-031 ptr=2, req=0011 -> gnt=0001 (wrap), then gnt=0010.
REQ-032 req asserted during PULSE by another requester -> no second gnt until after done; granted at done+2.
REQ-033 rst_n pulled low in second PULSE cycle of a set -> s_out=0 asynchronously, done never pulses, q_shadow=0.
REQ-034 Every cycle of all tests: assert !(s_out && r_out) and $onehot0(gnt).
